// File: rtl/decrypt_pkg.sv
// Shared types and constants for the AES-128 decrypt scheduling controller.
// Holds the datapath latency, key count, FSM state encoding and key index type.
package decrypt_pkg;

    localparam int LATENCY_C  = 11;
    localparam int NUM_KEYS_C = 11;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD
    } state_t;

    typedef logic [3:0] key_idx_t;

endpackage

// File: rtl/dec_out_fifo.sv
// Synchronous FIFO with occupancy count and registered out_valid.
// Ports: clk, rst (async high), i_push/i_data, i_pop, o_data, o_valid, o_count.
module dec_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_valid;
    logic          w_pop;
    logic          w_full;

    assign w_pop  = i_pop && r_valid;
    assign w_full = (r_count == CW'(DEPTH));

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!i_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_valid = r_valid;
    assign o_count = r_count;

    // The upstream credit scheme must never overfill the buffer.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(i_push && w_full && !w_pop)
    );

endmodule

// File: rtl/decrypt_sched_ctrl.sv
// Flow control and round-key store around an 11-stage AES-128 decrypt pipe.
// Ports: in_* ciphertext handshake, dp_* datapath link, round_keys, key_* update
// handshake, out_* plaintext handshake, busy.
module decrypt_sched_ctrl
    import decrypt_pkg::*;
#(
    parameter int LATENCY    = LATENCY_C,
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [127:0]               in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [127:0]               dp_cypher_text,
    input  logic [127:0]               dp_plain_text,
    output logic [NUM_KEYS_C*128-1:0]  round_keys,
    input  logic                       key_req,
    input  logic                       key_wr_valid,
    output logic                       key_wr_ready,
    input  key_idx_t                   key_wr_idx,
    input  logic [127:0]               key_wr_data,
    input  logic                       key_wr_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [127:0]               out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       busy
);

    localparam int IW = $clog2(LATENCY+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [LATENCY-1:0]         r_vld;
    logic [TAG_W-1:0]           r_tag [LATENCY];
    logic [IW-1:0]              r_inflight;
    logic [NUM_KEYS_C*128-1:0]  r_keys;
    logic [CW-1:0]              w_fifo_count;
    logic [SW-1:0]              w_credit;
    logic                       w_acc;
    logic                       w_exit;
    logic                       w_kwr;

    // Outstanding work: blocks in the pipe plus results already buffered.
    assign w_credit = SW'(r_inflight) + SW'(w_fifo_count);

    assign in_ready = !rst && (r_state == RUN) && !key_req &&
                      (w_credit < SW'(FIFO_DEPTH));
    assign w_acc    = in_valid && in_ready;
    assign w_exit   = r_vld[LATENCY-1];

    assign dp_cypher_text = in_data;
    assign key_wr_ready   = (r_state == LOAD);
    assign w_kwr          = key_wr_valid && key_wr_ready;
    assign round_keys     = r_keys;
    assign busy           = (r_state != RUN) || (w_credit != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++)
                r_tag[i] <= '0;
        end else begin
            r_vld    <= {r_vld[LATENCY-2:0], w_acc};
            r_tag[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_inflight <= '0;
        else if (w_acc && !w_exit)
            r_inflight <= r_inflight + 1'b1;
        else if (!w_acc && w_exit)
            r_inflight <= r_inflight - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (key_req) w_state_nxt = DRAIN;
            DRAIN:   if (r_inflight == '0) w_state_nxt = LOAD;
            LOAD:    if (w_kwr && key_wr_last) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Indices past the last key are accepted but dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keys <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS_C; i++)
                if (w_kwr && key_wr_idx == key_idx_t'(i))
                    r_keys[i*128 +: 128] <= key_wr_data;
        end
    end

    dec_out_fifo #(
        .W     (128 + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_exit),
        .i_data  ({dp_plain_text, r_tag[LATENCY-1]}),
        .i_pop   (out_valid && out_ready),
        .o_data  ({out_data, out_tag}),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_decrypt_sched_ctrl.sv
// Scoreboard bench for decrypt_sched_ctrl with a behavioural 11-cycle datapath.
// Inputs change 1ns after posedge; outputs and handshakes are sampled at negedge.
module tb_decrypt_sched_ctrl;

    localparam int LAT   = 11;
    localparam int TAG_W = 4;
    localparam int NK    = 11;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_RK [NK] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_data;
    logic [TAG_W-1:0]   in_tag;
    logic [127:0]       dp_cypher_text;
    logic [127:0]       dp_plain_text;
    logic [NK*128-1:0]  round_keys;
    logic               key_req;
    logic               key_wr_valid;
    logic               key_wr_ready;
    logic [3:0]         key_wr_idx;
    logic [127:0]       key_wr_data;
    logic               key_wr_last;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_out  = 0;

    logic [127:0] tbk [NK];
    logic [131:0] sbq [$];
    logic [127:0] dp_pipe [LAT];

    decrypt_sched_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_tag         (in_tag),
        .dp_cypher_text (dp_cypher_text),
        .dp_plain_text  (dp_plain_text),
        .round_keys     (round_keys),
        .key_req        (key_req),
        .key_wr_valid   (key_wr_valid),
        .key_wr_ready   (key_wr_ready),
        .key_wr_idx     (key_wr_idx),
        .key_wr_data    (key_wr_data),
        .key_wr_last    (key_wr_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the AES core: real answer for the FIPS vector, XOR otherwise.
    function automatic logic [127:0] dp_fn(input logic [127:0] ct,
                                           input logic [127:0] k0,
                                           input logic [127:0] k10);
        if (ct == FIPS_CT && k0 == FIPS_RK[0] && k10 == FIPS_RK[10])
            return FIPS_PT;
        return ct ^ k0 ^ k10;
    endfunction

    always @(posedge clk) begin
        dp_pipe[0] <= dp_fn(dp_cypher_text, round_keys[127:0],
                            round_keys[NK*128-1 -: 128]);
        for (int i = 1; i < LAT; i++)
            dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_plain_text = dp_pipe[LAT-1];

    task automatic chk(input string tag, input logic [131:0] got,
                       input logic [131:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sbq.push_back({dp_fn(in_data, tbk[0], tbk[10]), in_tag});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_has_entry", 132'(sbq.size() != 0), 132'(1));
                if (sbq.size() != 0)
                    chk("sb_data", {out_data, out_tag}, sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag);
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            smp();
            w++;
        end
        chk(tag, 132'(sbq.size()), 132'(0));
    endtask

    task automatic wait_load();
        int w;
        w = 0;
        smp();
        while (!key_wr_ready && w < 60) begin
            smp();
            w++;
        end
        chk("load_entry", 132'(key_wr_ready), 132'(1));
    endtask

    task automatic key_pulse();
        tick();
        key_req = 1'b1;
        smp();
        chk("kreq_in_ready", 132'(in_ready), 132'(0));
        tick();
        key_req = 1'b0;
    endtask

    task automatic write_keys(input bit fips);
        logic [127:0] nk [NK];
        for (int i = 0; i < NK; i++)
            nk[i] = fips ? FIPS_RK[i]
                         : {$urandom, $urandom, $urandom, $urandom};
        tick();
        key_wr_valid = 1'b1;
        key_wr_idx   = 4'd15;
        key_wr_data  = {4{32'hdeadbeef}};
        key_wr_last  = 1'b0;
        for (int i = 0; i < NK; i++) begin
            tick();
            key_wr_idx  = 4'(i);
            key_wr_data = nk[i];
            key_wr_last = (i == NK - 1);
        end
        tick();
        key_wr_valid = 1'b0;
        key_wr_last  = 1'b0;
        for (int i = 0; i < NK; i++)
            tbk[i] = nk[i];
        smp();
        for (int i = 0; i < NK; i++)
            chk($sformatf("rk%0d", i), 132'(round_keys[i*128 +: 128]),
                132'(nk[i]));
        chk("post_load_ready", 132'(in_ready), 132'(1));
        chk("post_load_kwr", 132'(key_wr_ready), 132'(0));
    endtask

    task automatic stream(input int cycles, input int max_acc);
        int a0;
        a0 = n_acc;
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_tag  = TAG_W'(n_acc - a0);
            smp();
            if (n_acc - a0 >= max_acc)
                break;
            tick();
        end
    endtask

    initial begin
        int a0;
        int o0;
        int lat;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_tag       = '0;
        key_req      = 1'b0;
        key_wr_valid = 1'b0;
        key_wr_idx   = '0;
        key_wr_data  = '0;
        key_wr_last  = 1'b0;
        out_ready    = 1'b1;
        for (int i = 0; i < NK; i++)
            tbk[i] = '0;

        repeat (3) @(posedge clk);
        smp();
        chk("rst_in_ready", 132'(in_ready), 132'(0));
        chk("rst_out_valid", 132'(out_valid), 132'(0));
        tick();
        rst = 1'b0;
        smp();
        chk("rel_in_ready", 132'(in_ready), 132'(1));
        chk("rel_out_valid", 132'(out_valid), 132'(0));
        chk("rel_kwr_ready", 132'(key_wr_ready), 132'(0));
        chk("rel_busy", 132'(busy), 132'(0));
        chk("rel_rk_zero", 132'(|round_keys), 132'(0));

        key_pulse();
        wait_load();
        write_keys(1'b1);

        tick();
        in_valid = 1'b1;
        in_data  = FIPS_CT;
        in_tag   = 4'd3;
        smp();
        chk("fips_acc", 132'(in_ready), 132'(1));
        tick();
        in_valid = 1'b0;
        lat = 1;
        smp();
        while (!out_valid && lat < 30) begin
            smp();
            lat++;
        end
        chk("fips_latency", 132'(lat), 132'(12));
        chk("fips_pt", {out_data, out_tag}, {FIPS_PT, 4'd3});
        wait_empty("fips_drain");
        smp();
        chk("idle_busy", 132'(busy), 132'(0));

        tick();
        out_ready = 1'b0;
        a0 = n_acc;
        o0 = n_out;
        stream(40, 20);
        tick();
        in_valid = 1'b0;
        smp();
        chk("bp_accepted", 132'(n_acc - a0), 132'(16));
        chk("bp_in_ready", 132'(in_ready), 132'(0));
        chk("bp_out_valid", 132'(out_valid), 132'(1));
        tick();
        out_ready = 1'b1;
        wait_empty("bp_drain");
        chk("bp_outputs", 132'(n_out - o0), 132'(16));
        chk("bp_ready_back", 132'(in_ready), 132'(1));

        tick();
        out_ready = 1'b0;
        stream(40, 100);
        chk("full_in_ready", 132'(in_ready), 132'(0));
        tick();
        out_ready = 1'b1;
        o0 = n_out;
        for (int k = 0; k < 30; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_tag  = TAG_W'($urandom);
            smp();
            tick();
        end
        chk("full_rate", 132'(n_out - o0), 132'(30));
        in_valid = 1'b0;
        wait_empty("full_drain");

        a0 = n_acc;
        o0 = n_out;
        stream(20, 5);
        chk("kr_accepted", 132'(n_acc - a0), 132'(5));
        tick();
        in_data = {$urandom, $urandom, $urandom, $urandom};
        key_req = 1'b1;
        smp();
        chk("kr_in_ready", 132'(in_ready), 132'(0));
        chk("kr_busy", 132'(busy), 132'(1));
        tick();
        key_req  = 1'b0;
        in_valid = 1'b0;
        wait_load();
        chk("kr_drained", 132'(n_out - o0), 132'(5));
        chk("kr_sb_empty", 132'(sbq.size()), 132'(0));
        write_keys(1'b0);
        tick();
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_tag   = 4'd9;
        smp();
        chk("newkey_acc", 132'(in_ready), 132'(1));
        tick();
        in_valid = 1'b0;
        wait_empty("newkey_drain");

        tick();
        out_ready = 1'b0;
        stream(10, 4);
        tick();
        in_valid = 1'b0;
        repeat (14) smp();
        chk("mid_buffered", 132'(out_valid), 132'(1));
        a0 = n_acc;
        stream(20, 8);
        chk("mid_accepted", 132'(n_acc - a0), 132'(8));
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 132'(out_valid), 132'(0));
        chk("mid_rst_in_ready", 132'(in_ready), 132'(0));
        sbq.delete();
        for (int i = 0; i < NK; i++)
            tbk[i] = '0;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        o0 = n_out;
        repeat (30) smp();
        chk("stale_outputs", 132'(n_out - o0), 132'(0));
        chk("post_rst_rk", 132'(|round_keys), 132'(0));
        chk("post_rst_busy", 132'(busy), 132'(0));
        chk("post_rst_ready", 132'(in_ready), 132'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
